// File: rtl/reg_desp_param_pkg.sv
// Shared constants and types for the parametrised universal shift register.
package reg_desp_param_pkg;

    // Operating mode as presented on MODO.
    typedef enum logic [1:0] {
        ModoShift = 2'b00,
        ModoRot   = 2'b01,
        ModoLoad  = 2'b10,
        ModoBurst = 2'b11
    } modo_e;

    // Controller state.
    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // One-hot next-op select handed from the controller to the datapath.
    typedef enum logic [3:0] {
        OpHold  = 4'b0001,
        OpShift = 4'b0010,
        OpRot   = 4'b0100,
        OpLoad  = 4'b1000
    } op_e;

endpackage

// File: rtl/reg_desp_fsm.sv
// Burst controller: owns state, burst counter, latched direction, BUSY and DONE,
// and tells the datapath which operation to apply on the next edge.
module reg_desp_fsm
    import reg_desp_param_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enb_i,
    input  logic       dir_i,
    input  logic [1:0] modo_i,
    output op_e        opSel_o,
    output logic       dirEff_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    state_e          stateQ, stateD;
    logic [CNTW-1:0] cntQ, cntD;
    logic            dirQ, dirD;
    logic            busyQ, busyD;
    logic            doneQ, doneD;

    // Direction is frozen for the whole burst so DIR may change under it.
    assign dirEff_o = busyQ ? dirQ : dir_i;
    assign busy_o   = busyQ;
    assign done_o   = doneQ;

    // Next-state and op-select decode; ENB=0 leaves everything at hold.
    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        dirD    = dirQ;
        busyD   = busyQ;
        doneD   = 1'b0;
        opSel_o = OpHold;
        if (enb_i) begin
            unique case (stateQ)
                StIdle: begin
                    unique case (modo_e'(modo_i))
                        ModoShift: opSel_o = OpShift;
                        ModoRot:   opSel_o = OpRot;
                        ModoLoad:  opSel_o = OpLoad;
                        ModoBurst: begin
                            // Start edge already performs the first of WIDTH shifts.
                            opSel_o = OpShift;
                            dirD    = dir_i;
                            cntD    = CNTW'(WIDTH - 1);
                            busyD   = 1'b1;
                            stateD  = StShift;
                        end
                        default: opSel_o = OpHold;
                    endcase
                end
                StShift: begin
                    opSel_o = OpShift;
                    cntD    = cntQ - CNTW'(1);
                    if (cntQ == CNTW'(1)) begin
                        busyD  = 1'b0;
                        doneD  = 1'b1;
                        stateD = StIdle;
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    // State register with synchronous reset; reset aborts any burst.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            dirQ   <= 1'b0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            dirQ   <= dirD;
            busyQ  <= busyD;
            doneQ  <= doneD;
        end
    end

endmodule

// File: rtl/reg_desp_param.sv
// WIDTH-bit universal shift register with hold/shift/rotate/load and a
// full-duplex burst mode that serialises the word out while filling from S_IN.
module reg_desp_param
    import reg_desp_param_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);

    op_e             opSel;
    logic            dirEff;
    logic [WIDTH-1:0] qD;

    reg_desp_fsm #(
        .WIDTH (WIDTH)
    ) uFsm (
        .clk_i    (CLK),
        .rst_i    (RST),
        .enb_i    (ENB),
        .dir_i    (DIR),
        .modo_i   (MODO),
        .opSel_o  (opSel),
        .dirEff_o (dirEff),
        .busy_o   (BUSY),
        .done_o   (DONE)
    );

    // Outgoing bit is the one about to fall off the end in the effective direction.
    assign S_OUT = dirEff ? Q[WIDTH-1] : Q[0];

    // Single next-Q mux selected by the controller's one-hot op.
    always_comb begin
        qD = Q;
        unique case (opSel)
            OpShift: qD = dirEff ? {Q[WIDTH-2:0], S_IN} : {S_IN, Q[WIDTH-1:1]};
            OpRot:   qD = dirEff ? {Q[WIDTH-2:0], Q[WIDTH-1]} : {Q[0], Q[WIDTH-1:1]};
            OpLoad:  qD = D;
            default: qD = Q;
        endcase
    end

    // Register update with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else begin
            Q <= qD;
        end
    end

endmodule

// File: tb/tb_reg_desp_param.sv
// Self-checking bench: directed table, hand-written burst sequences at WIDTH=8
// and WIDTH=32, and randomized stimulus against a behavioural model.
module tb_reg_desp_param;

    logic        clk = 1'b0;
    logic        rst, enb, dir, sin;
    logic [1:0]  modo;
    logic [7:0]  d8, q8;
    logic        sout8, busy8, done8;
    logic [31:0] d32, q32;
    logic        sout32, busy32, done32;

    int nVec = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    reg_desp_param #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(sin), .MODO(modo),
        .D(d8), .Q(q8), .S_OUT(sout8), .BUSY(busy8), .DONE(done8)
    );

    reg_desp_param #(.WIDTH(32)) dut32 (
        .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(sin), .MODO(modo),
        .D(d32), .Q(q32), .S_OUT(sout32), .BUSY(busy32), .DONE(done32)
    );

    typedef struct {
        logic       rst, enb, dir, sin;
        logic [1:0] modo;
        logic [7:0] d;
        logic [7:0] q;
        logic       busy, done, sout;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic dr, input logic s,
                         input logic [1:0] m, input logic [7:0] dv);
        rst = r; enb = e; dir = dr; sin = s; modo = m; d8 = dv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load, then one WIDTH=8 burst with an optional ENB=0 stall after stallAt shifts.
    task automatic runBurst8(input string name, input logic [7:0] init, input logic dirv,
                             input logic [7:0] sinv, input int stallAt, input int stallLen);
        int k = 0, stall = 0, cyc = 0, busyEdges = 0, doneCnt = 0;
        logic stalling, expBit;
        logic [7:0] qHold, expQ;
        drive(0, 1, dirv, 0, 2'b10, init);
        tick();
        chk({name, "_load"}, q8, init);
        while (k < 8 && cyc < 40) begin
            stalling = (k == stallAt) && (stall < stallLen);
            expBit   = dirv ? init[7-k] : init[k];
            // After the start edge DIR is inverted and MODO=10 to prove both are ignored.
            drive(0, !stalling, (k == 0) ? dirv : !dirv, sinv[k],
                  (k == 0) ? 2'b11 : 2'b10, ~init);
            #1;
            chk({name, "_sout"}, sout8, expBit);
            qHold = q8;
            tick();
            cyc++;
            if (stalling) begin
                stall++;
                chk({name, "_stallQ"}, q8, qHold);
                chk({name, "_stallBusy"}, busy8, 1'b1);
                chk({name, "_stallDone"}, done8, 1'b0);
            end else begin
                k++;
            end
            if (busy8) busyEdges++;
            if (done8) doneCnt++;
        end
        for (int j = 0; j < 8; j++) begin
            if (dirv) expQ[7-j] = sinv[j];
            else      expQ[j]   = sinv[j];
        end
        chk({name, "_cycles"}, cyc, 8 + stallLen);
        chk({name, "_busyCycles"}, busyEdges, 7 + stallLen);
        chk({name, "_doneEnd"}, done8, 1'b1);
        chk({name, "_busyEnd"}, busy8, 1'b0);
        chk({name, "_donePulses"}, doneCnt, 1);
        chk({name, "_finalQ"}, q8, expQ);
        drive(0, 0, 0, 0, 2'b00, 8'h00);
        tick();
        chk({name, "_doneDrops"}, done8, 1'b0);
    endtask

    // Behavioural model state for the randomized phase.
    logic [7:0] mq;
    logic       mbusy, mdone, mdir;
    int         mrem;

    function automatic logic [7:0] mShift(input logic [7:0] q, input logic left, input logic s);
        if (left) return 8'((q * 2) | s);
        else      return 8'((q / 2) | (s * 128));
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        d32 = '0;
        drive(1, 0, 0, 0, 2'b00, 8'h00);

        //         rst   enb   dir   sin   modo   d      q      busy  done  sout
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 8'h00, 8'h4B, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 8'h00, 8'h96, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 8'h00, 8'h2D, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 8'h00, 8'h96, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 8'h00, 8'h4B, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 8'h81, 8'h81, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 8'h00, 8'hE0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'hE0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].enb, tbl[i].dir, tbl[i].sin, tbl[i].modo, tbl[i].d);
            tick();
            chk($sformatf("tbl%0d_q", i), q8, tbl[i].q);
            chk($sformatf("tbl%0d_busy", i), busy8, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done8, tbl[i].done);
            chk($sformatf("tbl%0d_sout", i), sout8, tbl[i].sout);
        end

        // Burst left from C3 with S_IN 1,0,1,0,...; then the same with a 3-cycle stall.
        runBurst8("burstL", 8'hC3, 1'b1, 8'b0101_0101, 99, 0);
        runBurst8("stallL", 8'hC3, 1'b1, 8'b0101_0101, 4, 3);
        runBurst8("burstR", 8'h3C, 1'b0, 8'b1100_1010, 99, 0);
        runBurst8("stallR", 8'h96, 1'b0, 8'b0011_0110, 2, 2);

        // Reset in the middle of a burst discards it.
        drive(0, 1, 1, 0, 2'b10, 8'hC3);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 0, 2'b11, 8'h00);
            tick();
        end
        drive(1, 1, 1, 0, 2'b11, 8'h00);
        tick();
        chk("rstMid_q", q8, 8'h00);
        chk("rstMid_busy", busy8, 1'b0);
        chk("rstMid_done", done8, 1'b0);
        drive(0, 0, 0, 0, 2'b00, 8'h00);
        tick();
        chk("rstMid_stillIdle", busy8, 1'b0);

        // Back-to-back bursts with MODO=11 held through DONE.
        drive(0, 1, 0, 0, 2'b10, 8'h0F);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 0, 2'b11, 8'h00);
            tick();
        end
        chk("b2b_done1", done8, 1'b1);
        chk("b2b_q1", q8, 8'h00);
        drive(0, 1, 0, 1, 2'b11, 8'h00);
        tick();
        chk("b2b_busy2", busy8, 1'b1);
        chk("b2b_noDone", done8, 1'b0);
        chk("b2b_q2start", q8, 8'h80);
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_done2", done8, 1'b1);
        chk("b2b_q2", q8, 8'hFF);

        // Randomized phase against the behavioural model.
        drive(1, 0, 0, 0, 2'b00, 8'h00);
        tick();
        mq = 8'h00; mbusy = 1'b0; mdone = 1'b0; mdir = 1'b0; mrem = 0;
        for (int n = 0; n < 600; n++) begin
            logic r, e, dr, s, expSout;
            logic [1:0] m;
            logic [7:0] dv;
            r  = ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 5) != 0);
            dr = 1'($urandom);
            s  = 1'($urandom);
            m  = 2'($urandom);
            dv = 8'($urandom);
            drive(r, e, dr, s, m, dv);
            #1;
            expSout = (mbusy ? mdir : dr) ? mq[7] : mq[0];
            chk("rand_sout", sout8, expSout);
            if (r) begin
                mq = 8'h00; mbusy = 1'b0; mdone = 1'b0; mdir = 1'b0; mrem = 0;
            end else if (!e) begin
                mdone = 1'b0;
            end else if (mbusy) begin
                mq   = mShift(mq, mdir, s);
                mrem = mrem - 1;
                mdone = (mrem == 0);
                mbusy = (mrem != 0);
            end else begin
                mdone = 1'b0;
                case (m)
                    2'b00: mq = mShift(mq, dr, s);
                    2'b01: mq = mShift(mq, dr, dr ? mq[7] : mq[0]);
                    2'b10: mq = dv;
                    default: begin
                        mdir  = dr;
                        mq    = mShift(mq, dr, s);
                        mrem  = 7;
                        mbusy = 1'b1;
                    end
                endcase
            end
            tick();
            chk("rand_q", q8, mq);
            chk("rand_busy", busy8, mbusy);
            chk("rand_done", done8, mdone);
        end

        // WIDTH=32 burst: DONE exactly 32 edges after start.
        begin
            logic [31:0] init32, sin32, exp32;
            logic        dir32;
            int          doneAt;
            int          doneCnt;
            doneAt = -1;
            doneCnt = 0;
            drive(1, 0, 0, 0, 2'b00, 8'h00);
            tick();
            init32 = $urandom;
            sin32  = $urandom;
            dir32  = 1'($urandom);
            d32    = init32;
            drive(0, 1, dir32, 0, 2'b10, 8'h00);
            tick();
            chk("w32_load", q32, init32);
            for (int k = 0; k < 32; k++) begin
                drive(0, 1, (k == 0) ? dir32 : !dir32, sin32[k], (k == 0) ? 2'b11 : 2'b10, 8'h00);
                #1;
                chk("w32_sout", sout32, dir32 ? init32[31-k] : init32[k]);
                tick();
                if (done32) begin
                    doneCnt++;
                    doneAt = k + 1;
                end
            end
            for (int j = 0; j < 32; j++) begin
                if (dir32) exp32[31-j] = sin32[j];
                else       exp32[j]    = sin32[j];
            end
            chk("w32_doneAt", doneAt, 32);
            chk("w32_donePulses", doneCnt, 1);
            chk("w32_busyEnd", busy32, 1'b0);
            chk("w32_finalQ", q32, exp32);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
